// File: rtl/token_receiver_if.sv
// token_receiver_if: writer send/ack handshake plus ring-side valid/ready stream of token_receiver.
// rx_count_o_tr is carried only when TOKEN_RX_COUNT_EN is defined.
interface token_receiver_if #(parameter int DEPTH = 4);
    localparam int LW = $clog2(DEPTH) + 1;
    logic          send_i_tr;
    logic [61:0]   token_i_tr;
    logic          ack_o_tr;
    logic [61:0]   token_o_tr;
    logic          valid_o_tr;
    logic          ready_i_tr;
    logic [LW-1:0] level_o_tr;
`ifdef TOKEN_RX_COUNT_EN
    logic [15:0]   rx_count_o_tr;
    modport master (output send_i_tr, token_i_tr, ready_i_tr,
                    input ack_o_tr, token_o_tr, valid_o_tr, level_o_tr, rx_count_o_tr);
    modport slave  (input send_i_tr, token_i_tr, ready_i_tr,
                    output ack_o_tr, token_o_tr, valid_o_tr, level_o_tr, rx_count_o_tr);
`else
    modport master (output send_i_tr, token_i_tr, ready_i_tr,
                    input ack_o_tr, token_o_tr, valid_o_tr, level_o_tr);
    modport slave  (input send_i_tr, token_i_tr, ready_i_tr,
                    output ack_o_tr, token_o_tr, valid_o_tr, level_o_tr);
`endif
endinterface

// File: rtl/token_receiver.sv
// token_receiver: 4-phase send/ack token slave feeding a FWFT FIFO drained over valid/ready.
// TOKEN_RX_COUNT_EN adds a wrapping 16-bit accepted-token counter.
module token_receiver #(parameter int DEPTH = 4) (
    input logic clk,
    input logic rst,
    token_receiver_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_ACK = 2'd1} rx_state_t;
    rx_state_t     state;
    logic          ack;
    logic          valid;
    logic [LW-1:0] level;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [61:0]   mem [DEPTH];
    logic          push;
    logic          pop;
    logic [LW-1:0] level_nxt;
    // full test uses the registered level, so a same-cycle pop never frees a slot for a push
    assign push      = (state == RX_IDLE) && bus.send_i_tr && (level != LW'(DEPTH));
    assign pop       = valid && bus.ready_i_tr;
    assign level_nxt = level + LW'(push) - LW'(pop);
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RX_IDLE;
            ack    <= 1'b0;
            valid  <= 1'b0;
            level  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            case (state)
                RX_IDLE: if (push) begin
                    state <= RX_ACK;
                    ack   <= 1'b1;
                end
                RX_ACK: if (!bus.send_i_tr) begin
                    state <= RX_IDLE;
                    ack   <= 1'b0;
                end
                default: begin
                    state <= RX_IDLE;
                    ack   <= 1'b0;
                end
            endcase
            level  <= level_nxt;
            valid  <= level_nxt != '0;
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.token_i_tr;
    end
    assign bus.ack_o_tr   = ack;
    assign bus.valid_o_tr = valid;
    assign bus.level_o_tr = level;
    assign bus.token_o_tr = valid ? mem[rd_ptr] : 62'h0;
`ifdef TOKEN_RX_COUNT_EN
    logic [15:0] rx_count;
    always_ff @(posedge clk) begin
        if (rst) rx_count <= '0;
        else if (push) rx_count <= rx_count + 16'd1;
    end
    assign bus.rx_count_o_tr = rx_count;
`endif
endmodule
